rv_multicycle_ctrl: RTL and testbench

- Parametrised multi-cycle control FSM for the RV32I datapath. It replaces the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several clock cycles.
- Handshakes with a variable-latency memory port (req/ready) and aborts on bus timeout or illegal opcode.
- Counts retired instructions.

---
 rtl/rv_ctrl_pkg.sv | 27 ++
 rtl/rv_mem_timeout.sv | 19 +
 rtl/rv_multicycle_ctrl.sv | 131 +++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, FSM states, instruction classes and control-field encodings
// shared by rv_multicycle_ctrl and its testbench.
package rv_ctrl_pkg;
    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_I     = 7'b0010011,
        OP_AUIPC = 7'b0010111,
        OP_STORE = 7'b0100011,
        OP_R     = 7'b0110011,
        OP_LUI   = 7'b0110111,
        OP_BR    = 7'b1100011,
        OP_JALR  = 7'b1100111,
        OP_JAL   = 7'b1101111
    } opcode_t;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;
    typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC} cls_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_BR, ALU_FN} alu_op_t;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_4} srcb_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_t;
    typedef enum logic [1:0] {PC_4, PC_BR, PC_JR} pc_t;
endpackage

// File: rtl/rv_mem_timeout.sv
// rv_mem_timeout: counts unanswered memory-request cycles and flags expiry on the
// cycle the limit is reached, unless that same cycle carries mem_ready.
module rv_mem_timeout #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    assign expired = inc && cnt == TO_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32I control FSM with memory handshake, timeout and instret.
// Define RV_CTRL_UTYPE_EN to accept LUI/AUIPC; otherwise they trap as illegal.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal_insn,
    output logic             bus_error,
    output logic             halted
);
    logic [2:0] state, nx;
    cls_t       cls, dec_cls;
    logic       dec_ok, expired;

    rv_mem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_to (
        .clk(clk),
        .reset(reset),
        .clr(!mem_req || mem_ready),
        .inc(mem_req && !mem_ready),
        .expired(expired)
    );

    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = C_R;
        case (opcode)
            OP_R:     dec_cls = C_R;
            OP_I:     dec_cls = C_I;
            OP_LOAD:  dec_cls = C_LOAD;
            OP_STORE: dec_cls = C_STORE;
            OP_BR:    dec_cls = C_BR;
            OP_JAL:   dec_cls = C_JAL;
            OP_JALR:  dec_cls = C_JALR;
`ifdef RV_CTRL_UTYPE_EN
            OP_LUI:   dec_cls = C_LUI;
            OP_AUIPC: dec_cls = C_AUIPC;
`endif
            default:  dec_ok = 1'b0;
        endcase
    end

    // Moore decode of state/class; only completing-cycle strobes look at mem_ready/branch_taken
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        pc_write  = 1'b0;
        pc_src    = PC_4;
        retire    = 1'b0;
        halted    = 1'b0;
        nx        = state;
        case (state)
            S_IDLE: nx = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                nx       = mem_ready ? S_DECODE : expired ? S_TRAP : S_FETCH;
            end
            S_DECODE: nx = dec_ok ? S_EXEC : S_TRAP;
            S_EXEC: begin
                alu_op    = (cls == C_R || cls == C_I) ? ALU_FN : cls == C_BR ? ALU_BR : ALU_ADD;
                alu_src_b = (cls == C_I || cls == C_LOAD || cls == C_STORE || cls == C_AUIPC) ? SRCB_IMM : SRCB_RS2;
                alu_src_a = cls == C_AUIPC;
                pc_write  = cls == C_BR;
                pc_src    = (cls == C_BR && branch_taken) ? PC_BR : PC_4;
                retire    = cls == C_BR;
                nx        = cls == C_BR ? S_FETCH : (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = cls == C_STORE;
                pc_write = mem_ready && cls == C_STORE;
                retire   = mem_ready && cls == C_STORE;
                nx       = mem_ready ? (cls == C_STORE ? S_FETCH : S_WB) : expired ? S_TRAP : S_MEM;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                wb_sel    = cls == C_LOAD ? WB_MEM : (cls == C_JAL || cls == C_JALR) ? WB_PC4 : cls == C_LUI ? WB_IMM : WB_ALU;
                pc_src    = cls == C_JAL ? PC_BR : cls == C_JALR ? PC_JR : PC_4;
                nx        = S_FETCH;
            end
            S_TRAP: halted = 1'b1;
            default: nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= S_IDLE;
            cls          <= C_R;
            instret      <= '0;
            illegal_insn <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            state <= nx;
            if (state == S_DECODE) cls <= dec_cls;
            if (retire) instret <= instret + 1'b1;
            if (state == S_DECODE && !dec_ok) illegal_insn <= 1'b1;
            if (expired) bus_error <= 1'b1;
        end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed per-scenario checks of rv_multicycle_ctrl
// built with TIMEOUT_CYCLES=4 and CNT_W=3 so timeout and instret wrap are reachable.
module tb_rv_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_write, alu_src_a, reg_write, pc_write, retire;
    logic       illegal_insn, bus_error, halted;
    logic [1:0] alu_src_b, alu_op, wb_sel, pc_src;
    logic [2:0] instret;
    logic [16:0] sig;
    int tests = 0;
    int fails = 0;

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(3), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src), .retire(retire), .instret(instret),
        .illegal_insn(illegal_insn), .bus_error(bus_error), .halted(halted)
    );

    always #5 clk = ~clk;
    assign sig = {mem_req, mem_we, addr_sel, ir_write, alu_src_a, alu_src_b, alu_op,
                  reg_write, wb_sel, pc_write, pc_src, retire, halted};

    function automatic logic [16:0] mk(input logic req, we, as, irw, asa, input logic [1:0] sb, op,
                                       input logic rw, input logic [1:0] wb, input logic pcw,
                                       input logic [1:0] ps, input logic ret, hlt);
        return {req, we, as, irw, asa, sb, op, rw, wb, pcw, ps, ret, hlt};
    endfunction

    localparam logic [16:0] V_Z   = 17'd0;
    localparam logic [16:0] V_FW  = mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
    localparam logic [16:0] V_FR  = mk(1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
    localparam logic [16:0] V_ER  = mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 0, 2'd0, 0, 2'd0, 0, 0);
    localparam logic [16:0] V_ELS = mk(0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
    localparam logic [16:0] V_EBT = mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 1, 2'd1, 1, 0);
    localparam logic [16:0] V_EBN = mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 1, 2'd0, 1, 0);
    localparam logic [16:0] V_MLW = mk(1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
    localparam logic [16:0] V_MSW = mk(1, 1, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
    localparam logic [16:0] V_MSR = mk(1, 1, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 1, 2'd0, 1, 0);
    localparam logic [16:0] V_WR  = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd0, 1, 2'd0, 1, 0);
    localparam logic [16:0] V_WL  = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd1, 1, 2'd0, 1, 0);
    localparam logic [16:0] V_WJ  = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 1, 2'd1, 1, 0);
    localparam logic [16:0] V_WJR = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 1, 2'd2, 1, 0);
    localparam logic [16:0] V_T   = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 1);

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({sig, instret, illegal_insn, bus_error} !== 22'd0) begin
            fails++;
            $display("FAIL reset_hold got sig=%h instret=%0d ill=%b be=%b exp all 0", sig, instret, illegal_insn, bus_error);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (sig !== V_Z) begin fails++; $display("FAIL reset_idle got %h exp %h", sig, V_Z); end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [16:0] ev [4];
        ev = '{V_FR, V_Z, V_ER, V_WR};
        opcode = 7'b0110011;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (sig !== ev[i]) begin fails++; $display("FAIL add cyc%0d got %h exp %h", i + 1, sig, ev[i]); end
            @(negedge clk);
        end
        tests++;
        if (instret !== 3'd1) begin fails++; $display("FAIL add_instret got %0d exp 1", instret); end
    endtask

    task automatic test_lw_wait();
        logic [16:0] ev [8];
        bit rd [8];
        ev = '{V_FR, V_Z, V_ELS, V_MLW, V_MLW, V_MLW, V_MLW, V_WL};
        rd = '{1, 1, 1, 0, 0, 0, 1, 0};
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i];
            #1;
            tests++;
            if (sig !== ev[i]) begin fails++; $display("FAIL lw cyc%0d got %h exp %h", i + 1, sig, ev[i]); end
            @(negedge clk);
        end
        tests++;
        if (instret !== 3'd2 || bus_error !== 1'b0) begin
            fails++;
            $display("FAIL lw_end got instret=%0d be=%b exp 2/0", instret, bus_error);
        end
    endtask

    task automatic test_sw();
        logic [16:0] ev [5];
        bit rd [5];
        ev = '{V_FR, V_Z, V_ELS, V_MSW, V_MSR};
        rd = '{1, 1, 1, 0, 1};
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rd[i];
            #1;
            tests++;
            if (sig !== ev[i]) begin fails++; $display("FAIL sw cyc%0d got %h exp %h", i + 1, sig, ev[i]); end
            @(negedge clk);
        end
        tests++;
        if (instret !== 3'd3) begin fails++; $display("FAIL sw_instret got %0d exp 3", instret); end
    endtask

    task automatic test_branch();
        logic [16:0] ev [6];
        ev = '{V_FR, V_Z, V_EBT, V_FR, V_Z, V_EBN};
        opcode = 7'b1100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            branch_taken = i < 3;
            #1;
            tests++;
            if (sig !== ev[i]) begin fails++; $display("FAIL beq cyc%0d got %h exp %h", i + 1, sig, ev[i]); end
            @(negedge clk);
        end
        branch_taken = 1'b0;
        tests++;
        if (instret !== 3'd5) begin fails++; $display("FAIL beq_instret got %0d exp 5", instret); end
    endtask

    task automatic test_jump();
        logic [16:0] ev [8];
        ev = '{V_FR, V_Z, V_Z, V_WJ, V_FR, V_Z, V_Z, V_WJR};
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            opcode = i < 4 ? 7'b1101111 : 7'b1100111;
            #1;
            tests++;
            if (sig !== ev[i]) begin fails++; $display("FAIL jal_jalr cyc%0d got %h exp %h", i + 1, sig, ev[i]); end
            @(negedge clk);
        end
        tests++;
        if (instret !== 3'd7) begin fails++; $display("FAIL jump_instret got %0d exp 7", instret); end
    endtask

    task automatic test_timeout();
        logic [16:0] ev [7];
        bit rd [7];
        ev = '{V_FW, V_FW, V_FW, V_FR, V_Z, V_ER, V_WR};
        rd = '{0, 0, 0, 1, 1, 1, 1};
        opcode = 7'b0110011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rd[i];
            #1;
            tests++;
            if (sig !== ev[i]) begin fails++; $display("FAIL to_edge cyc%0d got %h exp %h", i + 1, sig, ev[i]); end
            @(negedge clk);
        end
        tests++;
        if (bus_error !== 1'b0 || instret !== 3'd0) begin
            fails++;
            $display("FAIL to_edge_end got be=%b instret=%0d exp 0/0", bus_error, instret);
        end
        ev = '{V_FW, V_FW, V_FW, V_FW, V_T, V_T, V_T};
        mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            tests++;
            if (sig !== ev[i]) begin fails++; $display("FAIL to_expire cyc%0d got %h exp %h", i + 1, sig, ev[i]); end
            @(negedge clk);
        end
        tests++;
        if (bus_error !== 1'b1 || illegal_insn !== 1'b0) begin
            fails++;
            $display("FAIL to_flags got be=%b ill=%b exp 1/0", bus_error, illegal_insn);
        end
        do_reset();
    endtask

    task automatic test_illegal();
        logic [16:0] e;
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            e = i == 0 ? V_FR : i == 1 ? V_Z : V_T;
            #1;
            tests++;
            if (sig !== e) begin fails++; $display("FAIL illegal cyc%0d got %h exp %h", i + 1, sig, e); end
            @(negedge clk);
        end
        tests++;
        if (illegal_insn !== 1'b1 || bus_error !== 1'b0 || instret !== 3'd0) begin
            fails++;
            $display("FAIL illegal_flags got ill=%b be=%b instret=%0d exp 1/0/0", illegal_insn, bus_error, instret);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_mem();
        opcode = 7'b0110011;
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        opcode = 7'b0000011;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (sig !== V_MLW || instret !== 3'd1) begin
            fails++;
            $display("FAIL mid_pre got sig=%h instret=%0d exp %h/1", sig, instret, V_MLW);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0 || sig !== V_Z || instret !== 3'd0) begin
            fails++;
            $display("FAIL mid_async got req=%b sig=%h instret=%0d exp 0/0/0", mem_req, sig, instret);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (sig !== V_Z) begin fails++; $display("FAIL mid_idle got %h exp %h", sig, V_Z); end
        @(negedge clk);
        #1;
        tests++;
        if (sig !== V_FW) begin fails++; $display("FAIL mid_fetch got %h exp %h", sig, V_FW); end
    endtask

    task automatic test_wrap();
        logic [16:0] ev [3];
        ev = '{V_FR, V_Z, V_EBN};
        opcode = 7'b1100011;
        branch_taken = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 3; i++) begin
                #1;
                tests++;
                if (sig !== ev[i]) begin fails++; $display("FAIL wrap br%0d cyc%0d got %h exp %h", k, i + 1, sig, ev[i]); end
                @(negedge clk);
            end
            if (k == 7) begin
                tests++;
                if (instret !== 3'd0) begin fails++; $display("FAIL wrap8 got %0d exp 0", instret); end
            end
        end
        tests++;
        if (instret !== 3'd1) begin fails++; $display("FAIL wrap9 got %0d exp 1", instret); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
